// File: rtl/alu_pipe.sv
// Pipelined ALU: single-cycle binary SUM/SUB/logic/shift, with an extra
// DEC_ADJ cycle for BCD add/subtract correction.
module alu_pipe #(
   parameter int WIDTH      = 8,
   parameter int DECIMAL_EN = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_op,
   input  logic             i_dec,
   input  logic             i_cin,
   input  logic [WIDTH-1:0] i_ai,
   input  logic [WIDTH-1:0] i_bi,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_add,
   output logic             o_acr,
   output logic             o_avr,
   output logic             o_hcr,
   output logic             o_z,
   output logic             o_n
);

   localparam int       NIB    = WIDTH / 4;
   localparam bit       DEC_ON = (DECIMAL_EN != 0);
   localparam bit [2:0] OP_SUM = 3'd0;
   localparam bit [2:0] OP_AND = 3'd1;
   localparam bit [2:0] OP_OR  = 3'd2;
   localparam bit [2:0] OP_EOR = 3'd3;
   localparam bit [2:0] OP_SR  = 3'd4;
   localparam bit [2:0] OP_SUB = 3'd5;

   typedef enum logic {IDLE = 1'b0, DEC_ADJ = 1'b1} state_t;
   state_t state, state_nxt;

   logic             accept, is_dec_op, is_legal_op;
   logic [WIDTH-1:0] h_ai, h_bi;
   logic             h_cin, h_sub;
   logic [WIDTH-1:0] a, bp, dres, flag_src;
   logic             cin, sub, hcr_b, avr_b, dacr, dc, bc;
   logic [WIDTH:0]   bsum;
   logic [4:0]       hn, bn, dn;
   logic [WIDTH-1:0] r_add;
   logic             r_acr, r_avr, r_hcr;

   assign accept      = i_valid && o_ready;
   assign is_legal_op = (i_op <= OP_SUB);
   assign is_dec_op   = DEC_ON && i_dec && ((i_op == OP_SUM) || (i_op == OP_SUB));

   // FSM: state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = IDLE;
      if (state == IDLE && accept && is_dec_op) state_nxt = DEC_ADJ;
   end

   // FSM: outputs
   always_comb begin
      o_ready = (state == IDLE) && !i_rst;
   end

   // Decimal operands are parked here so the correction cycle sees stable inputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         h_ai  <= '0;
         h_bi  <= '0;
         h_cin <= 1'b0;
         h_sub <= 1'b0;
      end else if (accept && is_dec_op) begin
         h_ai  <= i_ai;
         h_bi  <= i_bi;
         h_cin <= i_cin;
         h_sub <= (i_op == OP_SUB);
      end
   end

   assign a   = (state == DEC_ADJ) ? h_ai  : i_ai;
   assign cin = (state == DEC_ADJ) ? h_cin : i_cin;
   assign sub = (state == DEC_ADJ) ? h_sub : (i_op == OP_SUB);
   assign bp  = (state == DEC_ADJ) ? (h_sub ? ~h_bi : h_bi) : (sub ? ~i_bi : i_bi);

   // Binary adder plus per-nibble BCD correction chains.
   always_comb begin
      bsum  = {1'b0, a} + {1'b0, bp} + {{WIDTH{1'b0}}, cin};
      hn    = {1'b0, a[3:0]} + {1'b0, bp[3:0]} + {4'b0, cin};
      hcr_b = hn[4];
      avr_b = (a[WIDTH-1] == bp[WIDTH-1]) && (bsum[WIDTH-1] != a[WIDTH-1]);
      dres  = '0;
      bc    = cin;
      dc    = cin;
      bn    = '0;
      dn    = '0;
      for (int i = 0; i < NIB; i++) begin
         bn = {1'b0, a[4*i +: 4]} + {1'b0, bp[4*i +: 4]} + {4'b0, bc};
         dn = {1'b0, a[4*i +: 4]} + {1'b0, bp[4*i +: 4]} + {4'b0, dc};
         if (sub) begin
            dres[4*i +: 4] = bn[4] ? bn[3:0] : (bn[3:0] - 4'd6);
         end else if (dn > 5'd9) begin
            dres[4*i +: 4] = dn[3:0] + 4'd6;
            dc = 1'b1;
         end else begin
            dres[4*i +: 4] = dn[3:0];
            dc = 1'b0;
         end
         bc = bn[4];
      end
      dacr = sub ? bsum[WIDTH] : dc;
   end

   always_comb begin
      r_add = bsum[WIDTH-1:0];
      r_acr = bsum[WIDTH];
      r_avr = avr_b;
      r_hcr = hcr_b;
      if (state == DEC_ADJ) begin
         r_add = dres;
         r_acr = dacr;
      end else begin
         case (i_op)
            OP_AND, OP_OR, OP_EOR: begin
               r_add = (i_op == OP_AND) ? (i_ai & i_bi) :
                       (i_op == OP_OR)  ? (i_ai | i_bi) : (i_ai ^ i_bi);
               r_acr = 1'b0;
               r_avr = 1'b0;
               r_hcr = 1'b0;
            end
            OP_SR: begin
               r_add = {i_cin, i_ai[WIDTH-1:1]};
               r_acr = i_ai[0];
               r_avr = 1'b0;
               r_hcr = 1'b0;
            end
            default: ;
         endcase
      end
      // Decimal Z/N come from the uncorrected binary sum.
      flag_src = (state == DEC_ADJ) ? bsum[WIDTH-1:0] : r_add;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_valid <= 1'b0;
         o_add   <= '0;
         o_acr   <= 1'b0;
         o_avr   <= 1'b0;
         o_hcr   <= 1'b0;
         o_z     <= 1'b0;
         o_n     <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if ((state == DEC_ADJ) || (accept && is_legal_op && !is_dec_op)) begin
            o_valid <= 1'b1;
            o_add   <= r_add;
            o_acr   <= r_acr;
            o_avr   <= r_avr;
            o_hcr   <= r_hcr;
            o_z     <= (flag_src == '0);
            o_n     <= flag_src[WIDTH-1];
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed scoreboard bench for alu_pipe at WIDTH=8 and WIDTH=16.
module tb_alu_pipe;

   localparam logic [2:0] OP_SUM = 3'd0, OP_AND = 3'd1, OP_OR = 3'd2,
                          OP_EOR = 3'd3, OP_SR = 3'd4, OP_SUB = 3'd5;

   logic clk, rst;

   // 8-bit instance
   logic       valid8, rdy8, dec8, cin8, ovalid8, acr8, avr8, hcr8, z8, n8;
   logic [2:0] op8;
   logic [7:0] a8, b8, add8;

   // 16-bit instance
   logic        valid16, rdy16, dec16, cin16, ovalid16, acr16, avr16, hcr16, z16, n16;
   logic [2:0]  op16;
   logic [15:0] a16, b16, add16;

   logic [12:0] exp8_q[$];
   logic [20:0] exp16_q[$];
   int checks = 0;
   int errors = 0;

   alu_pipe #(.WIDTH(8), .DECIMAL_EN(1)) u_dut8 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid8), .o_ready(rdy8), .i_op(op8),
      .i_dec(dec8), .i_cin(cin8), .i_ai(a8), .i_bi(b8), .o_valid(ovalid8),
      .o_add(add8), .o_acr(acr8), .o_avr(avr8), .o_hcr(hcr8), .o_z(z8), .o_n(n8)
   );

   alu_pipe #(.WIDTH(16), .DECIMAL_EN(1)) u_dut16 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid16), .o_ready(rdy16), .i_op(op16),
      .i_dec(dec16), .i_cin(cin16), .i_ai(a16), .i_bi(b16), .o_valid(ovalid16),
      .o_add(add16), .o_acr(acr16), .o_avr(avr16), .o_hcr(hcr16), .o_z(z16), .o_n(n16)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic apply8(input logic [2:0] op, input logic dec, input logic cin,
                         input logic [7:0] a, input logic [7:0] b);
      op8 = op; dec8 = dec; cin8 = cin; a8 = a; b8 = b; valid8 = 1'b1;
      @(posedge clk); #1;
      valid8 = 1'b0;
   endtask

   task automatic apply16(input logic [2:0] op, input logic dec, input logic cin,
                          input logic [15:0] a, input logic [15:0] b);
      op16 = op; dec16 = dec; cin16 = cin; a16 = a; b16 = b; valid16 = 1'b1;
      @(posedge clk); #1;
      valid16 = 1'b0;
   endtask

   task automatic push8(input logic [7:0] add, input logic acr, input logic avr,
                        input logic hcr, input logic z, input logic n);
      exp8_q.push_back({add, acr, avr, hcr, z, n});
   endtask

   task automatic push16(input logic [15:0] add, input logic acr, input logic avr,
                         input logic hcr, input logic z, input logic n);
      exp16_q.push_back({add, acr, avr, hcr, z, n});
   endtask

   task automatic wait_ready8();
      int n = 0;
      while (!rdy8 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check("ready8_timeout", {31'd0, rdy8}, 32'd1);
   endtask

   task automatic wait_ready16();
      int n = 0;
      while (!rdy16 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check("ready16_timeout", {31'd0, rdy16}, 32'd1);
   endtask

   // scoreboard monitors
   always @(negedge clk) begin
      if (!rst && ovalid8) begin
         if (exp8_q.size() == 0) check("stray_valid8", {31'd0, ovalid8}, 32'd0);
         else check("result8", {19'd0, add8, acr8, avr8, hcr8, z8, n8}, {19'd0, exp8_q.pop_front()});
      end
   end

   always @(negedge clk) begin
      if (!rst && ovalid16) begin
         if (exp16_q.size() == 0) check("stray_valid16", {31'd0, ovalid16}, 32'd0);
         else check("result16", {11'd0, add16, acr16, avr16, hcr16, z16, n16}, {11'd0, exp16_q.pop_front()});
      end
   end

   // stimulus
   initial begin
      rst = 1'b1;
      valid8 = 1'b0; op8 = '0; dec8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
      valid16 = 1'b0; op16 = '0; dec16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;
      repeat (2) @(posedge clk); #1;
      check("rst_add8", {24'd0, add8}, 32'd0);
      check("rst_flags8", {26'd0, acr8, avr8, hcr8, z8, n8, ovalid8}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("ready_after_rst", {31'd0, rdy8}, 32'd1);

      push8(8'hA0, 0, 1, 0, 0, 1); apply8(OP_SUM, 0, 0, 8'h50, 8'h50);
      check("bin_sum_ready", {31'd0, rdy8}, 32'd1);

      push8(8'h05, 1, 1, 0, 0, 1); apply8(OP_SUM, 1, 1, 8'h58, 8'h46);
      check("dec_sum_busy", {31'd0, rdy8}, 32'd0);
      wait_ready8();

      push8(8'h34, 1, 0, 1, 0, 0); apply8(OP_SUB, 1, 1, 8'h46, 8'h12);
      check("dec_sub_busy", {31'd0, rdy8}, 32'd0);
      wait_ready8();
      push8(8'h91, 0, 0, 1, 0, 1); apply8(OP_SUB, 1, 1, 8'h12, 8'h21);
      wait_ready8();

      push8(8'hC0, 1, 0, 0, 0, 1); apply8(OP_SR,  0, 1, 8'h81, 8'h00);
      push8(8'h00, 0, 0, 0, 1, 0); apply8(OP_AND, 0, 0, 8'hF0, 8'h0F);
      push8(8'hAF, 0, 0, 0, 0, 1); apply8(OP_OR,  0, 0, 8'hA5, 8'h0F);
      push8(8'h00, 0, 0, 0, 1, 0); apply8(OP_EOR, 0, 0, 8'hFF, 8'hFF);
      push8(8'h0F, 1, 0, 0, 0, 0); apply8(OP_SUB, 0, 1, 8'h10, 8'h01);
      push8(8'h00, 1, 0, 1, 1, 0); apply8(OP_SUM, 0, 0, 8'hFF, 8'h01);
      push8(8'h0C, 0, 0, 0, 0, 0); apply8(OP_AND, 1, 0, 8'h3C, 8'h0F);
      check("and_dec_ready", {31'd0, rdy8}, 32'd1);

      // reserved opcode: no result, outputs hold
      apply8(3'd6, 0, 1, 8'h12, 8'h34);
      check("rsv_ready", {31'd0, rdy8}, 32'd1);
      @(posedge clk); #1;
      check("rsv_hold_add", {24'd0, add8}, 32'h0C);

      // valid held through DEC_ADJ must be ignored
      push8(8'h47, 0, 0, 1, 0, 0); apply8(OP_SUM, 1, 0, 8'h19, 8'h28);
      op8 = OP_AND; dec8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; valid8 = 1'b1;
      @(posedge clk); #1;
      valid8 = 1'b0;
      check("hold_ready_back", {31'd0, rdy8}, 32'd1);
      repeat (2) @(posedge clk); #1;

      // reset during DEC_ADJ aborts
      apply8(OP_SUM, 1, 1, 8'h58, 8'h46);
      check("abort_busy", {31'd0, rdy8}, 32'd0);
      rst = 1'b1;
      #2;
      check("abort_add", {24'd0, add8}, 32'd0);
      check("abort_flags", {26'd0, acr8, avr8, hcr8, z8, n8, ovalid8}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort_ready", {31'd0, rdy8}, 32'd1);
      repeat (3) @(posedge clk); #1;

      // 16-bit datapath
      push16(16'h0000, 1, 0, 0, 0, 1); apply16(OP_SUM, 1, 0, 16'h9999, 16'h0001);
      check("dec16_busy", {31'd0, rdy16}, 32'd0);
      wait_ready16();
      push16(16'h8000, 0, 1, 1, 0, 1); apply16(OP_SUM, 0, 0, 16'h7FFF, 16'h0001);

      repeat (3) @(posedge clk); #1;
      check("q8_drained", exp8_q.size(), 32'd0);
      check("q16_drained", exp16_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: datapath width in bits; legal values are multiples of 4 and at least 4.
REQ-002 SHALL have parameter DECIMAL_EN, default 1: 1 enables BCD add/subtract; 0 removes it.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_valid  input  1  operation request.
REQ-006 SHALL have port o_ready  output  1  the block can accept an operation this cycle.
REQ-007 SHALL have port i_op  input  3  opcode: 0 SUM, 1 AND, 2 OR, 3 EOR, 4 SR, 5 SUB; 6 and 7 are reserved.
REQ-008 SHALL have port i_dec  input  1  decimal mode for SUM/SUB.
REQ-009 SHALL have port i_cin  input  1  carry in (IADDC).
REQ-010 SHALL have port i_ai  input  WIDTH  A operand.
REQ-011 SHALL have port i_bi  input  WIDTH  B operand.
REQ-012 SHALL have port o_valid  output  1  one-cycle pulse marking a new result.
REQ-013 SHALL have port o_add  output  WIDTH  result (ADD register).
REQ-014 SHALL have port o_acr  output  1  carry out (ACR).
REQ-015 SHALL have port o_avr  output  1  signed overflow (AVR).
REQ-016 SHALL have port o_hcr  output  1  binary carry out of bit 3.
REQ-017 SHALL have port o_z  output  1  zero flag.
REQ-018 SHALL have port o_n  output  1  negative flag.

Function
REQ-019 SHALL accept an operation only in a cycle where i_valid=1 and o_ready=1; i_valid while o_ready=0 SHALL be ignored with no state change.
REQ-020 Binary ops, and all ops when DECIMAL_EN=0 or i_dec=0, SHALL have latency 1: results and o_valid=1 appear the cycle after acceptance.
REQ-021 Decimal SUM/SUB (DECIMAL_EN=1, i_dec=1) SHALL have latency 2: o_ready=0 and o_valid=0 in cycle+1; result, o_valid=1 and o_ready=1 in cycle+2.
REQ-022 The state machine SHALL have states IDLE (o_ready=1) and DEC_ADJ (o_ready=0); IDLE->DEC_ADJ on an accepted decimal op; DEC_ADJ->IDLE unconditionally after one cycle.
REQ-023 SUM SHALL compute {c,r} = ai + bi + cin over WIDTH+1 bits.
REQ-024 SUB SHALL compute {c,r} = ai + ~bi + cin over WIDTH+1 bits.
REQ-025 For SUM/SUB, o_acr=c, o_hcr=carry out of bit 3, and o_avr=(ai[MSB]==b'[MSB]) && (r[MSB]!=ai[MSB]), where b' is bi for SUM and ~bi for SUB.
REQ-026 Decimal SUM SHALL process nibbles from LSB upward: if nibble sum >9 or nibble carry is set, add 6; the adjusted nibble carry feeds the next nibble; o_acr = final adjusted carry.
REQ-027 Decimal SUB SHALL process nibbles using the binary nibble carries: any nibble with carry out 0 has 6 subtracted (mod 16); o_acr = binary carry c.
REQ-028 In decimal mode, o_z, o_n and o_avr SHALL be derived from the binary sum r, not from the corrected result; o_hcr SHALL be the binary bit-3 carry.
REQ-029 AND/OR/EOR SHALL give r = ai&bi, ai|bi or ai^bi, with o_acr=0, o_avr=0, o_hcr=0.
REQ-030 SR SHALL give o_add = {cin, ai[WIDTH-1:1]}, o_acr=ai[0], o_avr=0, o_hcr=0.
REQ-031 For all ops except where REQ-028 applies, o_z = (o_add==0) and o_n = o_add[MSB].
REQ-032 An accepted reserved opcode (6/7) SHALL leave all results unchanged, assert no o_valid, and keep o_ready=1.
REQ-033 o_add and all flags SHALL hold their last value until the next result.
REQ-034 o_valid SHALL be high for exactly one cycle per completed op.
REQ-035 With DECIMAL_EN=0, i_dec SHALL be ignored, o_ready SHALL be constant 1 outside reset, and DEC_ADJ SHALL be unreachable.

Reset
REQ-036 Asserting i_rst SHALL immediately force o_add=0, o_acr=0, o_avr=0, o_hcr=0, o_z=0, o_n=0, o_valid=0 and the state to IDLE.
REQ-037 Reset during DEC_ADJ SHALL abort the operation with no o_valid.
REQ-038 o_ready SHALL be 1 from the first clock after i_rst deasserts.

Verification
REQ-039 SUM 0x50+0x50, cin=0, i_dec=0 -> cycle+1: o_add=0xA0, acr=0, avr=1, n=1, z=0, o_valid=1.
REQ-040 Decimal SUM 0x58+0x46, cin=1 -> cycle+1 o_ready=0; cycle+2 o_add=0x05, acr=1, o_valid=1.
REQ-041 Decimal SUB 0x46-0x12, cin=1 -> o_add=0x34, acr=1; then 0x12-0x21, cin=1 -> o_add=0x91, acr=0.
REQ-042 SR ai=0x81, cin=1 -> o_add=0xC0, acr=1; AND 0xF0&0x0F -> o_add=0x00, z=1, acr=0.
REQ-043 i_valid held during DEC_ADJ -> ignored with exactly one o_valid; i_rst pulsed in DEC_ADJ -> all outputs 0 with no o_valid.
REQ-044 WIDTH=16: decimal SUM 0x9999+0x0001, cin=0 -> o_add=0x0000, acr=1, z=0 (binary 0x999A).
